// File: rtl/cache_tag_lookup.sv
// ---------------------------------------------------------------------------
// cache_tag_lookup
//
// Set-associative tag compare stage with a one-entry registered response
// buffer and per-set tree pseudo-LRU replacement state.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o lookup handshake (ready = response slot free)
//   req_addr_i          lookup address (tag + set index + word offset)
//   tagways_i           tag RAM read data for the request set, {valid, tag}
//   dataways_i          data RAM read data for the request set
//   rsp_valid_o/ready_i response handshake
//   rsp_data_o          OR of the hit-way data, zero on a miss
//   rsp_hit_o           at least one way hit
//   rsp_way_o           hit mask (multi-hot on a multi-hit)
//   rsp_victim_o        one-hot replacement way
//   rsp_multihit_o      more than one way hit
//   fill_valid_i        a line fill completed this cycle
//   fill_addr_i         fill address (only the set index is used)
//   fill_way_i          one-hot way that was filled
// ---------------------------------------------------------------------------
module cache_tag_lookup #(
    parameter int NUM_WAYS         = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int CLINE_SIZE_WORD  = 4,
    parameter int CLINE_ADDR_WIDTH = 7,
    localparam int TAG_OFF = $clog2(CLINE_SIZE_WORD) + CLINE_ADDR_WIDTH,
    localparam int TAG_W   = ADDR_WIDTH - TAG_OFF + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    input  logic [TAG_W*NUM_WAYS-1:0]      tagways_i,
    input  logic [DATA_WIDTH*NUM_WAYS-1:0] dataways_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic                           rsp_hit_o,
    output logic [NUM_WAYS-1:0]            rsp_way_o,
    output logic [NUM_WAYS-1:0]            rsp_victim_o,
    output logic                           rsp_multihit_o,
    input  logic                           fill_valid_i,
    input  logic [ADDR_WIDTH-1:0]          fill_addr_i,
    input  logic [NUM_WAYS-1:0]            fill_way_i
);

    localparam int WORD_OFF = $clog2(CLINE_SIZE_WORD);
    localparam int NUM_SETS = 1 << CLINE_ADDR_WIDTH;
    localparam int TAGF_W   = TAG_W - 1;

    function automatic int count_ones(input logic [NUM_WAYS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic int onehot_index(input logic [NUM_WAYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    logic [CLINE_ADDR_WIDTH-1:0] req_set;
    logic [CLINE_ADDR_WIDTH-1:0] fill_set;
    logic [TAGF_W-1:0]           req_tag;
    logic [NUM_WAYS-1:0]         way_valid;
    logic [NUM_WAYS-1:0]         hit_vec;
    logic [NUM_WAYS-1:0]         invalid_pick;
    logic [NUM_WAYS-1:0]         plru_victim;
    logic [DATA_WIDTH-1:0]       hit_data;
    logic                        accept;
    logic                        single_hit;
    logic                        multi_hit;
    logic                        fill_ok;
    logic                        unused_addr;

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic                  rsp_multihit_q, rsp_multihit_d;
    logic [NUM_WAYS-1:0]   rsp_way_q, rsp_way_d;
    logic [NUM_WAYS-1:0]   rsp_victim_q, rsp_victim_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    assign req_set     = req_addr_i[WORD_OFF +: CLINE_ADDR_WIDTH];
    assign fill_set    = fill_addr_i[WORD_OFF +: CLINE_ADDR_WIDTH];
    assign req_tag     = req_addr_i[TAG_OFF +: TAGF_W];
    // Word offset and fill tag bits are irrelevant to this stage.
    assign unused_addr = ^{req_addr_i, fill_addr_i};

    // The response slot can take a new request when it is empty or is being
    // drained this very cycle.
    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // Tag compare: each way carries its valid flag in the MSB of its tag
    // slice; hit data is the OR of every hitting way so a multi-hit still
    // produces a deterministic value.
    always_comb begin
        way_valid = '0;
        hit_vec   = '0;
        hit_data  = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            way_valid[i] = tagways_i[TAG_W*i + TAGF_W];
            hit_vec[i]   = way_valid[i] && (tagways_i[TAG_W*i +: TAGF_W] == req_tag);
            if (hit_vec[i]) begin
                hit_data = hit_data | dataways_i[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Empty ways are always preferred as victims; scanning from the top
    // down lets the lowest-index invalid way win.
    always_comb begin
        invalid_pick = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                invalid_pick    = '0;
                invalid_pick[i] = 1'b1;
            end
        end
    end

    assign single_hit = (count_ones(hit_vec) == 1);
    assign multi_hit  = (count_ones(hit_vec) > 1);
    assign fill_ok    = fill_valid_i && (count_ones(fill_way_i) == 1);

    generate
        if (NUM_WAYS > 1) begin : g_plru
            localparam int PLRU_W = NUM_WAYS - 1;

            logic [PLRU_W-1:0] plru_q [NUM_SETS];
            logic [PLRU_W-1:0] plru_d [NUM_SETS];

            // Depth of heap node n (root = 0, children of n at 2n+1 / 2n+2).
            function automatic int node_level(input int n);
                int l;
                l = 0;
                for (int k = 1; k < 4; k++) begin
                    if ((1 << k) <= n + 1) l = k;
                end
                return l;
            endfunction

            // Every node whose subtree contains the touched way is made to
            // point at the other half (1 = victim in the upper half).
            function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                             input int way);
                logic [PLRU_W-1:0] r;
                int lvl, span, pos;
                r = bits;
                for (int n = 0; n < PLRU_W; n++) begin
                    lvl  = node_level(n);
                    span = NUM_WAYS >> lvl;
                    pos  = n + 1 - (1 << lvl);
                    if ((way / span) == pos) begin
                        r[n] = ((way % span) < (span / 2));
                    end
                end
                return r;
            endfunction

            // A way is the victim when every node on its path points toward it.
            function automatic logic [NUM_WAYS-1:0] plru_pick(input logic [PLRU_W-1:0] bits);
                logic [NUM_WAYS-1:0] v;
                logic match;
                int lvl, span, pos;
                v = '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    match = 1'b1;
                    for (int n = 0; n < PLRU_W; n++) begin
                        lvl  = node_level(n);
                        span = NUM_WAYS >> lvl;
                        pos  = n + 1 - (1 << lvl);
                        if (((w / span) == pos) && (bits[n] != ((w % span) >= (span / 2)))) begin
                            match = 1'b0;
                        end
                    end
                    v[w] = match;
                end
                return v;
            endfunction

            // Fill touch first, lookup touch last, so a lookup hit in the
            // same set as a fill ends up as the most recently used way.
            always_comb begin
                plru_d = plru_q;
                if (fill_ok) begin
                    plru_d[fill_set] = plru_touch(plru_d[fill_set], onehot_index(fill_way_i));
                end
                if (accept && single_hit) begin
                    plru_d[req_set] = plru_touch(plru_d[req_set], onehot_index(hit_vec));
                end
            end

            // Replacement state storage, cleared to all-zero on reset.
            always_ff @(posedge clk_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    plru_q[s] <= rst_i ? '0 : plru_d[s];
                end
            end

            assign plru_victim = plru_pick(plru_q[req_set]);
        end else begin : g_no_plru
            assign plru_victim = '1;
        end
    endgenerate

    // Response buffer: loads on acceptance, empties when drained without a
    // replacement; payload holds otherwise so it is stable under stall.
    always_comb begin
        rsp_valid_d    = rsp_valid_q;
        rsp_hit_d      = rsp_hit_q;
        rsp_multihit_d = rsp_multihit_q;
        rsp_way_d      = rsp_way_q;
        rsp_victim_d   = rsp_victim_q;
        rsp_data_d     = rsp_data_q;
        if (accept) begin
            rsp_valid_d    = 1'b1;
            rsp_hit_d      = |hit_vec;
            rsp_multihit_d = multi_hit;
            rsp_way_d      = hit_vec;
            rsp_victim_d   = (|invalid_pick) ? invalid_pick : plru_victim;
            rsp_data_d     = hit_data;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_multihit_q <= 1'b0;
            rsp_way_q      <= '0;
            rsp_victim_q   <= '0;
            rsp_data_q     <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_multihit_q <= rsp_multihit_d;
            rsp_way_q      <= rsp_way_d;
            rsp_victim_q   <= rsp_victim_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_hit_o      = rsp_hit_q;
    assign rsp_multihit_o = rsp_multihit_q;
    assign rsp_way_o      = rsp_way_q;
    assign rsp_victim_o   = rsp_victim_q;
    assign rsp_data_o     = rsp_data_q;

endmodule

// File: doc/cache_tag_lookup.md
CACHE_TAG_LOOKUP -- requirements
Module: cache_tag_lookup

Interface
REQ-001 SHALL have parameters: NUM_WAYS, default 4, associativity, power of two in 1..8; ADDR_WIDTH, default 32, address bits; DATA_WIDTH, default 32, data word bits; CLINE_SIZE_WORD, default 4, words per line, power of two; CLINE_ADDR_WIDTH, default 7, set-index bits.
REQ-002 SHALL define TAG_OFF = clog2(CLINE_SIZE_WORD)+CLINE_ADDR_WIDTH; TAG_W = ADDR_WIDTH-TAG_OFF+1 (MSB = way valid bit); set index = addr[clog2(CLINE_SIZE_WORD) +: CLINE_ADDR_WIDTH].
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 req_valid_i  in  1  lookup request valid.
REQ-007 req_ready_o  out  1  lookup request accepted when high with req_valid_i.
REQ-008 req_addr_i  in  ADDR_WIDTH  lookup address.
REQ-009 tagways_i  in  TAG_W*NUM_WAYS  tag RAM read data for the request set, way i at [TAG_W*i +: TAG_W], aligned with the request.
REQ-010 dataways_i  in  DATA_WIDTH*NUM_WAYS  data RAM read data, aligned with the request.
REQ-011 rsp_valid_o  out  1  response valid.
REQ-012 rsp_ready_i  in  1  response consumer ready.
REQ-013 rsp_data_o  out  DATA_WIDTH  OR of hit-way data; 0 on miss.
REQ-014 rsp_hit_o  out  1  at least one way hit.
REQ-015 rsp_way_o  out  NUM_WAYS  one-hot (or multi-hot) hit mask.
REQ-016 rsp_victim_o  out  NUM_WAYS  one-hot replacement way.
REQ-017 rsp_multihit_o  out  1  more than one way hit (error).
REQ-018 fill_valid_i  in  1  line fill completed this cycle.
REQ-019 fill_addr_i  in  ADDR_WIDTH  fill address (set index used).
REQ-020 fill_way_i  in  NUM_WAYS  one-hot filled way.

Function
REQ-021 Way i SHALL hit when tag field of req_addr_i equals tagways_i way i tag bits and way i valid bit is 1.
REQ-022 Request SHALL be accepted when req_valid_i & req_ready_o; req_ready_o = !rsp_valid_o | rsp_ready_i (combinational).
REQ-023 Response SHALL appear registered 1 cycle after acceptance; rsp_valid_o clears on rsp_ready_i with no new acceptance.
REQ-024 All rsp_* outputs SHALL hold stable while rsp_valid_o & !rsp_ready_i.
REQ-025 SHALL keep NUM_WAYS-1 tree-PLRU bits per set in flops (none when NUM_WAYS=1); node bit 0 = victim in lower-index subtree.
REQ-026 Victim SHALL be lowest-index invalid way if any; else PLRU way from set state before this request's update; NUM_WAYS=1 -> victim always 1.
REQ-027 Single hit on acceptance SHALL touch hit way: path bits set to point away from it; miss and multi-hit SHALL leave PLRU unchanged.
REQ-028 fill_valid_i SHALL touch fill_way_i in fill set; zero or multi-hot fill_way_i SHALL be ignored.
REQ-029 Fill and lookup touch in same set same cycle: fill touch applied first, lookup touch last; victim uses pre-cycle state.
REQ-030 Multi-hit: rsp_hit_o=1, rsp_multihit_o=1, rsp_way_o = all hit ways, rsp_data_o = OR of hit data.

Reset
REQ-031 On rst_i: rsp_valid_o=0, rsp_data_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_victim_o=0, rsp_multihit_o=0, all PLRU bits 0; rst_i mid-operation SHALL drop any pending response; req_ready_o=1 the cycle after release.

Verification (NUM_WAYS=4, defaults; TAG_OFF=9; PLRU bits root,left,right)
REQ-032 Reset, lookup 0x0000_0200 (set 0, tag 1), all ways invalid -> next cycle rsp_valid_o=1, hit=0, way=0000, victim=0001, data=0.
REQ-033 All valid, way0 tag 1, dataway0=0xDEAD_BEEF, lookup 0x200 -> hit=1, way=0001, data=0xDEAD_BEEF, victim=0001; repeat with tag 2 (miss) -> victim=0100.
REQ-034 rsp_ready_i=0 for 3 cycles with rsp_valid_o=1 -> req_ready_o=0, outputs unchanged, new req_valid_i not accepted; rsp_ready_i=1 -> accepted same cycle.
REQ-035 Ways 1 and 3 valid with tag 1, data 0x0F/0xF0 -> hit=1, multihit=1, way=1010, data=0xFF; following all-valid miss -> victim=0001 (PLRU unchanged).
REQ-036 fill set 5 way 0, then all-valid miss in set 5 -> victim=0100; set 6 unaffected -> victim=0001.
REQ-037 rst_i asserted while rsp_valid_o=1 after REQ-033 touch -> next cycle rsp_valid_o=0; subsequent all-valid miss in set 0 -> victim=0001.
